// File: rtl/mux_seq_pkg.sv
// ---------------------------------------------------------------------------
// mux_seq_pkg
// Shared definitions for the 8:1 select-mux sequencer.
//   - state_t          : FSM state encoding (IDLE / SHIFT / DONE)
//   - DEF_WIDTH/SEL_W  : default code width and select width
//   - first_idx()      : first index presented for a given bit order
//   - last_idx()       : final index presented for a given bit order
// ---------------------------------------------------------------------------
package mux_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // LSB-first walks 0..width-1, MSB-first walks width-1..0.
    function automatic int first_idx(input bit msb_first, input int width);
        return msb_first ? (width - 1) : 0;
    endfunction

    function automatic int last_idx(input bit msb_first, input int width);
        return msb_first ? 0 : (width - 1);
    endfunction

endpackage

// File: rtl/mux_sel_sequencer_v_sel_counter.sv
// ---------------------------------------------------------------------------
// sel_counter_v
// Loadable up/down select counter with enable and terminal-index flag.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : step the counter by one
//   down       : 1 = decrement, 0 = increment
//   term_val   : terminal index to compare against
//   count      : current index
//   at_term    : count equals term_val
// ---------------------------------------------------------------------------
module sel_counter_v
    import mux_seq_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             en,
    input  logic             down,
    input  logic [SEL_W-1:0] term_val,
    output logic [SEL_W-1:0] count,
    output logic             at_term
);

    // Index register: load wins over stepping so a new word always starts
    // from its first index regardless of where the previous word ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= down ? (count - SEL_W'(1)) : (count + SEL_W'(1));
        end
    end

    assign at_term = (count == term_val);

endmodule

// File: rtl/mux_sel_sequencer_v.sv
// ---------------------------------------------------------------------------
// mux_sel_sequencer_v
// Drives an 8:1 select mux: holds an accepted word on o_code, walks
// o_sel_code through every index (one per unpaused clock), and rebuilds the
// mux output i_f into o_rx_code. o_match reports a per-word loopback check.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_code/i_valid/o_ready : word input handshake (ready only in IDLE)
//   i_pause       : freeze stepping and capture during SHIFT
//   o_code        : held word (to mux i_code)
//   o_sel_code    : current index (to mux i_sel_code)
//   i_f           : combinational mux return
//   o_busy/o_last/o_done   : SHIFT, final-index, and one-cycle DONE flags
//   o_rx_code/o_match      : reassembled word and its compare result
// ---------------------------------------------------------------------------
module mux_sel_sequencer_v
    import mux_seq_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEL_W     = DEF_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_code,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_pause,
    output logic [WIDTH-1:0] o_code,
    output logic [SEL_W-1:0] o_sel_code,
    input  logic             i_f,
    output logic             o_busy,
    output logic             o_last,
    output logic             o_done,
    output logic [WIDTH-1:0] o_rx_code,
    output logic             o_match
);

    localparam logic [SEL_W-1:0] FIRST = SEL_W'(first_idx(MSB_FIRST, WIDTH));
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(last_idx(MSB_FIRST, WIDTH));

    state_t           state;
    logic             accept;
    logic             step;
    logic             at_last;
    logic [WIDTH-1:0] rx_next;

    assign accept = (state == S_IDLE) && i_valid;
    assign step   = (state == S_SHIFT) && !i_pause;

    // The counter stops on the final index so o_sel_code holds it into DONE
    // and never wraps.
    sel_counter_v #(
        .SEL_W (SEL_W)
    ) u_sel_counter (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (accept),
        .load_val (FIRST),
        .en       (step && !at_last),
        .down     (MSB_FIRST),
        .term_val (LAST),
        .count    (o_sel_code),
        .at_term  (at_last)
    );

    // Next value of the capture register: the bit selected this cycle takes
    // the mux return. The compare on entry to DONE uses this so the final
    // bit is included.
    always_comb begin
        rx_next = o_rx_code;
        if (step) begin
            rx_next[o_sel_code] = i_f;
        end
    end

    // Main FSM with the held word, capture register and match flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= S_IDLE;
            o_code    <= '0;
            o_rx_code <= '0;
            o_match   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_valid) begin
                        o_code    <= i_code;
                        o_rx_code <= '0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    o_rx_code <= rx_next;
                    if (step && at_last) begin
                        o_match <= (rx_next == o_code);
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready = (state == S_IDLE);
    assign o_busy  = (state == S_SHIFT);
    assign o_done  = (state == S_DONE);
    assign o_last  = (state == S_SHIFT) && at_last;

endmodule

// File: tb/tb_mux_sel_sequencer_v.sv
// ---------------------------------------------------------------------------
// tb_mux_sel_sequencer_v
// Two sequencer instances (LSB-first and MSB-first), each looped back through
// a behavioural 8:1 mux with an optional stuck-at-0 fault on one index.
// Stimulus pushes the hand-computed expected result of each accepted word into
// a scoreboard queue; a negedge monitor walks the expected index sequence and
// pops/compares whenever a DUT pulses o_done.
// ---------------------------------------------------------------------------
module tb_mux_sel_sequencer_v;

    typedef struct {
        int         d;
        logic [7:0] code;
        logic [7:0] rx;
        logic       match;
        int         acc_cyc;
        int         done_cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] code_in   [2];
    logic       valid_in  [2];
    logic       pause_in  [2];
    logic       fault_en  [2];
    logic [2:0] fault_idx [2];

    logic [7:0] code_o  [2];
    logic [2:0] sel_o   [2];
    logic [7:0] rx_o    [2];
    logic       ready_o [2];
    logic       busy_o  [2];
    logic       last_o  [2];
    logic       done_o  [2];
    logic       match_o [2];
    logic       f_w     [2];

    exp_t       sbq [$];
    logic       trk [2];
    int         idx [2];
    exp_t       cur [2];

    always #5 clk = ~clk;

    // Cycle counter used to time expected o_done pulses.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural mux loopback with optional stuck-at-0 on one index.
    assign f_w[0] = (fault_en[0] && sel_o[0] == fault_idx[0]) ? 1'b0 : code_o[0][sel_o[0]];
    assign f_w[1] = (fault_en[1] && sel_o[1] == fault_idx[1]) ? 1'b0 : code_o[1][sel_o[1]];

    mux_sel_sequencer_v #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b0)) dut0 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_code     (code_in[0]),
        .i_valid    (valid_in[0]),
        .o_ready    (ready_o[0]),
        .i_pause    (pause_in[0]),
        .o_code     (code_o[0]),
        .o_sel_code (sel_o[0]),
        .i_f        (f_w[0]),
        .o_busy     (busy_o[0]),
        .o_last     (last_o[0]),
        .o_done     (done_o[0]),
        .o_rx_code  (rx_o[0]),
        .o_match    (match_o[0])
    );

    mux_sel_sequencer_v #(.WIDTH(8), .SEL_W(3), .MSB_FIRST(1'b1)) dut1 (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_code     (code_in[1]),
        .i_valid    (valid_in[1]),
        .o_ready    (ready_o[1]),
        .i_pause    (pause_in[1]),
        .o_code     (code_o[1]),
        .o_sel_code (sel_o[1]),
        .i_f        (f_w[1]),
        .o_busy     (busy_o[1]),
        .o_last     (last_o[1]),
        .o_done     (done_o[1]),
        .o_rx_code  (rx_o[1]),
        .o_match    (match_o[1])
    );

    task automatic checkOutput(input string name, input int d, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d @cyc %0d: got %0h, expected %0h", name, d, cyc, actual, expected);
        end
    endtask

    // Monitor: reset values while reset is seen, the expected index walk
    // during SHIFT, and the scoreboard pop on every o_done.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                trk[d] = 1'b0;
                checkOutput("rst_ready", d, int'(ready_o[d]), 1);
                checkOutput("rst_busy",  d, int'(busy_o[d]),  0);
                checkOutput("rst_last",  d, int'(last_o[d]),  0);
                checkOutput("rst_done",  d, int'(done_o[d]),  0);
                checkOutput("rst_code",  d, int'(code_o[d]),  0);
                checkOutput("rst_sel",   d, int'(sel_o[d]),   0);
                checkOutput("rst_rx",    d, int'(rx_o[d]),    0);
                checkOutput("rst_match", d, int'(match_o[d]), 0);
            end else begin
                if (!trk[d] && sbq.size() > 0 && sbq[0].d == d && cyc == sbq[0].acc_cyc) begin
                    trk[d] = 1'b1;
                    idx[d] = (d == 0) ? 0 : 7;
                    cur[d] = sbq[0];
                end
                if (trk[d]) begin
                    checkOutput("shift_busy",  d, int'(busy_o[d]),  1);
                    checkOutput("shift_ready", d, int'(ready_o[d]), 0);
                    checkOutput("shift_sel",   d, int'(sel_o[d]),   idx[d]);
                    checkOutput("shift_last",  d, int'(last_o[d]),  (idx[d] == ((d == 0) ? 7 : 0)) ? 1 : 0);
                    checkOutput("held_code",   d, int'(code_o[d]),  int'(cur[d].code));
                    if (!pause_in[d]) begin
                        if (idx[d] == ((d == 0) ? 7 : 0)) trk[d] = 1'b0;
                        else idx[d] = (d == 0) ? idx[d] + 1 : idx[d] - 1;
                    end
                end else if (busy_o[d]) begin
                    checkOutput("unexpected_busy", d, 1, 0);
                end
                if (done_o[d]) begin
                    if (sbq.size() > 0 && sbq[0].d == d) begin
                        checkOutput("done_latency", d, cyc, sbq[0].done_cyc);
                        checkOutput("done_rx",      d, int'(rx_o[d]),    int'(sbq[0].rx));
                        checkOutput("done_match",   d, int'(match_o[d]), int'(sbq[0].match));
                        checkOutput("done_ready",   d, int'(ready_o[d]), 0);
                        void'(sbq.pop_front());
                    end else begin
                        checkOutput("spurious_done", d, 1, 0);
                    end
                end else if (sbq.size() > 0 && sbq[0].d == d && cyc > sbq[0].done_cyc) begin
                    checkOutput("done_timeout", d, 0, 1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    // Offer a word, hold it until accepted, then record the hand-computed
    // expected result. done_cyc counts from the accept edge: WIDTH unpaused
    // SHIFT cycles plus any paused ones.
    task automatic applyStimulus(input int d, input logic [7:0] code, input logic [7:0] exp_rx,
                                 input logic exp_match, input int pause_len);
        exp_t e;
        bit   accepted;
        accepted = 1'b0;
        code_in[d]  = code;
        valid_in[d] = 1'b1;
        for (int n = 0; n < 60 && !accepted; n++) begin
            @(negedge clk);
            if (ready_o[d]) begin
                @(posedge clk);
                accepted = 1'b1;
            end
        end
        if (!accepted) begin
            $display("[TB] FAIL accept_timeout dut%0d: got no o_ready, expected o_ready", d);
            $fatal(1, "[TB] accept timeout");
        end
        #1;
        e.d = d;
        e.code = code;
        e.rx = exp_rx;
        e.match = exp_match;
        e.acc_cyc = cyc;
        e.done_cyc = cyc + 8 + pause_len;
        sbq.push_back(e);
        valid_in[d] = 1'b0;
    endtask

    task automatic waitIdle();
        repeat (14) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            code_in[d]   = 8'h00;
            valid_in[d]  = 1'b0;
            pause_in[d]  = 1'b0;
            fault_en[d]  = 1'b0;
            fault_idx[d] = 3'd0;
            trk[d]       = 1'b0;
            idx[d]       = 0;
        end
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // LSB-first loopback
        applyStimulus(0, 8'hA5, 8'hA5, 1'b1, 0);
        waitIdle();

        // MSB-first loopback
        applyStimulus(1, 8'h3C, 8'h3C, 1'b1, 0);
        waitIdle();

        // Pause for 3 cycles while index 4 is presented
        applyStimulus(0, 8'hFF, 8'hFF, 1'b1, 3);
        repeat (4) @(posedge clk);
        #1 pause_in[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 pause_in[0] = 1'b0;
        waitIdle();

        // Stuck-at-0 mux fault on index 2: 0F -> 0B
        fault_idx[0] = 3'd2;
        fault_en[0]  = 1'b1;
        applyStimulus(0, 8'h0F, 8'h0B, 1'b0, 0);
        waitIdle();
        fault_en[0]  = 1'b0;

        // Second word offered mid-SHIFT is held off until IDLE
        applyStimulus(0, 8'hC3, 8'hC3, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 8'h55, 8'h55, 1'b1, 0);
        waitIdle();

        // Reset while index 5 is presented, then a normal word
        applyStimulus(0, 8'h96, 8'h96, 1'b1, 0);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        applyStimulus(0, 8'h5A, 8'h5A, 1'b1, 0);
        waitIdle();

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
